// File: rtl/rv32_wb_bypass_if.sv
// Bundle between the pipeline and rv32_wb_bypass: RF read/write ports,
// execute result bus and forwarded operands.
interface rv32_wb_bypass_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0] rs1_addr_c1;
    logic [AW-1:0] rs2_addr_c1;
    logic [DW-1:0] rs1_dato_reg_c2;
    logic [DW-1:0] rs2_dato_reg_c2;
    logic          res_vld_c3;
    logic [AW-1:0] res_addr_c3;
    logic [DW-1:0] res_dat_c3;
    logic          c_rf_wr;
    logic [AW-1:0] rd_addr_c6;
    logic [DW-1:0] rd_dati;
    logic [DW-1:0] rs1_fwd_c2;
    logic [DW-1:0] rs2_fwd_c2;
    logic          rs1_hit_c2;
    logic          rs2_hit_c2;

    modport master (
        output rs1_addr_c1, rs2_addr_c1,
        output rs1_dato_reg_c2, rs2_dato_reg_c2,
        output res_vld_c3, res_addr_c3, res_dat_c3,
        input  c_rf_wr, rd_addr_c6, rd_dati,
        input  rs1_fwd_c2, rs2_fwd_c2, rs1_hit_c2, rs2_hit_c2
    );

    modport slave (
        input  rs1_addr_c1, rs2_addr_c1,
        input  rs1_dato_reg_c2, rs2_dato_reg_c2,
        input  res_vld_c3, res_addr_c3, res_dat_c3,
        output c_rf_wr, rd_addr_c6, rd_dati,
        output rs1_fwd_c2, rs2_fwd_c2, rs1_hit_c2, rs2_hit_c2
    );
endinterface

// File: rtl/rv32_wb_bypass.sv
// Writeback delay pipe (c3..c6) plus c2 operand bypass from c3..c7.
// Optional RV32_X0_ZERO_EN: register 0 hardwired to zero.
module rv32_wb_bypass #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    rv32_wb_bypass_if.slave bus
);

    logic          vld_c3;
    logic          vld_q  [4:7];
    logic [AW-1:0] addr_q [4:7];
    logic [DW-1:0] dat_q  [4:7];
    logic [AW-1:0] rs1_addr_c2;
    logic [AW-1:0] rs2_addr_c2;

`ifdef RV32_X0_ZERO_EN
    assign vld_c3 = bus.res_vld_c3 && (bus.res_addr_c3 != '0);
`else
    assign vld_c3 = bus.res_vld_c3;
`endif

    // c7 holds the entry written last edge, which the RF read missed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 4; i <= 7; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                dat_q[i]  <= '0;
            end
            rs1_addr_c2 <= '0;
            rs2_addr_c2 <= '0;
        end else begin
            vld_q[4]  <= vld_c3;
            addr_q[4] <= bus.res_addr_c3;
            dat_q[4]  <= bus.res_dat_c3;
            for (int i = 5; i <= 7; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
                dat_q[i]  <= dat_q[i-1];
            end
            rs1_addr_c2 <= bus.rs1_addr_c1;
            rs2_addr_c2 <= bus.rs2_addr_c1;
        end
    end

    assign bus.c_rf_wr    = vld_q[6];
    assign bus.rd_addr_c6 = addr_q[6];
    assign bus.rd_dati    = dat_q[6];

    // Oldest first so younger matches overwrite older ones
    function automatic logic [DW:0] bypass(
        input logic [AW-1:0] a,
        input logic [DW-1:0] rf,
        input logic          v3,
        input logic [AW-1:0] a3,
        input logic [DW-1:0] d3,
        input logic          v4, v5, v6, v7,
        input logic [AW-1:0] a4, a5, a6, a7,
        input logic [DW-1:0] d4, d5, d6, d7
    );
        logic [DW:0] r;
        r = {1'b0, rf};
        if (v7 && a7 == a) r = {1'b1, d7};
        if (v6 && a6 == a) r = {1'b1, d6};
        if (v5 && a5 == a) r = {1'b1, d5};
        if (v4 && a4 == a) r = {1'b1, d4};
        if (v3 && a3 == a) r = {1'b1, d3};
`ifdef RV32_X0_ZERO_EN
        if (a == '0) r = '0;
`endif
        return r;
    endfunction

    logic [DW:0] rs1_sel;
    logic [DW:0] rs2_sel;

    always_comb begin
        rs1_sel = bypass(rs1_addr_c2, bus.rs1_dato_reg_c2,
                         vld_c3, bus.res_addr_c3, bus.res_dat_c3,
                         vld_q[4], vld_q[5], vld_q[6], vld_q[7],
                         addr_q[4], addr_q[5], addr_q[6], addr_q[7],
                         dat_q[4], dat_q[5], dat_q[6], dat_q[7]);
        rs2_sel = bypass(rs2_addr_c2, bus.rs2_dato_reg_c2,
                         vld_c3, bus.res_addr_c3, bus.res_dat_c3,
                         vld_q[4], vld_q[5], vld_q[6], vld_q[7],
                         addr_q[4], addr_q[5], addr_q[6], addr_q[7],
                         dat_q[4], dat_q[5], dat_q[6], dat_q[7]);
    end

    assign bus.rs1_hit_c2 = rs1_sel[DW];
    assign bus.rs1_fwd_c2 = rs1_sel[DW-1:0];
    assign bus.rs2_hit_c2 = rs2_sel[DW];
    assign bus.rs2_fwd_c2 = rs2_sel[DW-1:0];

endmodule

// File: tb/tb_rv32_wb_bypass.sv
// Directed bench for rv32_wb_bypass: writeback latency, bypass priority,
// reset flush and the register-0 option.
module tb_rv32_wb_bypass;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] RF2 = 32'h2222_2222;

    rv32_wb_bypass_if #(.AW(8), .DW(32)) bus ();

    rv32_wb_bypass #(.AW(8), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic v, input logic [7:0] a,
                       input logic [31:0] d);
        bus.res_vld_c3  = v;
        bus.res_addr_c3 = a;
        bus.res_dat_c3  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rs1_addr_c1 = 8'h00;
        bus.rs2_addr_c1 = 8'h00;
        bus.rs1_dato_reg_c2 = RF1;
        bus.rs2_dato_reg_c2 = RF2;
        res(1'b0, 8'h00, 32'h0);
        #12;
        chk("rst_wr", {31'b0, bus.c_rf_wr}, 32'd0);
        chk("rst_addr", {24'b0, bus.rd_addr_c6}, 32'd0);
        chk("rst_dati", bus.rd_dati, 32'd0);
        chk("rst_hit1", {31'b0, bus.rs1_hit_c2}, 32'd0);
        chk("rst_hit2", {31'b0, bus.rs2_hit_c2}, 32'd0);
        chk("rst_fwd1", bus.rs1_fwd_c2, RF1);
        chk("rst_fwd2", bus.rs2_fwd_c2, RF2);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // r5 write walks c3..c8 while c2 reads r5
        bus.rs1_addr_c1 = 8'h05;
        step();
        res(1'b1, 8'h05, 32'hDEAD_BEEF);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("r5_hit_c%0d", i + 3), {31'b0, bus.rs1_hit_c2},
                (i < 5) ? 32'd1 : 32'd0);
            chk($sformatf("r5_fwd_c%0d", i + 3), bus.rs1_fwd_c2,
                (i < 5) ? 32'hDEAD_BEEF : RF1);
            chk($sformatf("r5_wr_t%0d", i), {31'b0, bus.c_rf_wr},
                (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                chk("r5_wr_addr", {24'b0, bus.rd_addr_c6}, 32'h05);
                chk("r5_wr_dat", bus.rd_dati, 32'hDEAD_BEEF);
            end
            step();
            res(1'b0, 8'h05, 32'h0);
            #1;
        end

        // back-to-back r7 writes: younger must win
        bus.rs1_addr_c1 = 8'h07;
        step();
        res(1'b1, 8'h07, 32'h0000_000A);
        step();
        res(1'b1, 8'h07, 32'h0000_000B);
        #1;
        chk("r7_c3_over_c4", bus.rs1_fwd_c2, 32'hB);
        step();
        res(1'b0, 8'h00, 32'h0);
        #1;
        chk("r7_c4_over_c5", bus.rs1_fwd_c2, 32'hB);
        step();
        chk("r7_c5_over_c6", bus.rs1_fwd_c2, 32'hB);
        chk("r7_c5_hit", {31'b0, bus.rs1_hit_c2}, 32'd1);
        step();
        chk("r7_c6_over_c7", bus.rs1_fwd_c2, 32'hB);

        // both operands on the same register
        bus.rs1_addr_c1 = 8'h09;
        bus.rs2_addr_c1 = 8'h09;
        step();
        res(1'b1, 8'h09, 32'h0000_1234);
        step();
        res(1'b0, 8'h09, 32'hFFFF_FFFF);
        #1;
        step();
        chk("same_fwd1", bus.rs1_fwd_c2, 32'h1234);
        chk("same_fwd2", bus.rs2_fwd_c2, 32'h1234);
        chk("same_hit1", {31'b0, bus.rs1_hit_c2}, 32'd1);
        chk("same_hit2", {31'b0, bus.rs2_hit_c2}, 32'd1);
        bus.rs2_addr_c1 = 8'h0A;
        step();
        chk("rs2_miss_fwd", bus.rs2_fwd_c2, RF2);
        chk("rs2_miss_hit", {31'b0, bus.rs2_hit_c2}, 32'd0);
        chk("rs1_c6_fwd", bus.rs1_fwd_c2, 32'h1234);

        // reset with three writes in flight
        bus.rs1_addr_c1 = 8'h01;
        res(1'b1, 8'h01, 32'h100);
        step();
        res(1'b1, 8'h02, 32'h200);
        step();
        res(1'b1, 8'h03, 32'h300);
        step();
        res(1'b0, 8'h00, 32'h0);
        #1;
        chk("flush_pre_wr", {31'b0, bus.c_rf_wr}, 32'd1);
        chk("flush_pre_addr", {24'b0, bus.rd_addr_c6}, 32'h01);
        rst_n = 1'b0;
        #1;
        chk("flush_async_wr", {31'b0, bus.c_rf_wr}, 32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("flush_post_wr%0d", i), {31'b0, bus.c_rf_wr},
                32'd0);
            if (i == 0) begin
                chk("flush_rd_fwd", bus.rs1_fwd_c2, RF1);
                chk("flush_rd_hit", {31'b0, bus.rs1_hit_c2}, 32'd0);
            end
        end

        // register 0 behaviour
        bus.rs1_addr_c1 = 8'h00;
        step();
        res(1'b1, 8'h00, 32'hFFFF_FFFF);
        #1;
`ifdef RV32_X0_ZERO_EN
        chk("x0_fwd", bus.rs1_fwd_c2, 32'h0);
        chk("x0_hit", {31'b0, bus.rs1_hit_c2}, 32'd0);
`else
        chk("x0_fwd", bus.rs1_fwd_c2, 32'hFFFF_FFFF);
        chk("x0_hit", {31'b0, bus.rs1_hit_c2}, 32'd1);
`endif
        step();
        res(1'b0, 8'h00, 32'h0);
        #1;
        step();
        step();
`ifdef RV32_X0_ZERO_EN
        chk("x0_wr", {31'b0, bus.c_rf_wr}, 32'd0);
`else
        chk("x0_wr", {31'b0, bus.c_rf_wr}, 32'd1);
        chk("x0_wr_dat", bus.rd_dati, 32'hFFFF_FFFF);
`endif
        step();
        chk("x0_wr_after", {31'b0, bus.c_rf_wr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
